udp_status_tx: RTL and testbench

Transmit-side application block for the UDP echo/status path: builds a fixed 8-byte status frame (current LED nibble, 16-bit digit display value, key inputs, sequence number, checksum). It delivers the frame to the UDP stack's application TX port with a request/acknowledge handshake. Frames are sent periodically and on demand. It is the counterpart of the receive-side LED payload parser and echoes that block's decoded outputs back to the host.

---
 rtl/udp_status_tx_if.sv | 26 ++
 rtl/udp_status_tx.sv | 160 ++++++++++++++++
 tb/tb_udp_status_tx.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/udp_status_tx_if.sv
// Application TX port between the status-frame builder and the UDP stack.
// Handshake: the master holds app_tx_data_request while app_tx_ack is low; once ack is seen,
// the request drops and app_tx_data_valid is asserted for 8 gap-free cycles, one byte per cycle.
interface udp_status_tx_if;
  logic        app_tx_ack;
  logic        app_tx_data_request;
  logic        app_tx_data_valid;
  logic [7:0]  app_tx_data;
  logic [15:0] app_tx_data_length;

  modport master (
    input  app_tx_ack,
    output app_tx_data_request,
    output app_tx_data_valid,
    output app_tx_data,
    output app_tx_data_length
  );

  modport slave (
    output app_tx_ack,
    input  app_tx_data_request,
    input  app_tx_data_valid,
    input  app_tx_data,
    input  app_tx_data_length
  );
endinterface

// File: rtl/udp_status_tx.sv
// Builds the 8-byte status frame (LEDs, digit display, keys, sequence, checksum) and hands it
// to the UDP stack's application TX port, periodically and on send_trig.
module udp_status_tx #(
  parameter int unsigned PERIOD_CYCLES = 125_000_000,
  parameter int unsigned ACK_TIMEOUT   = 1024
) (
  input  logic              udp_tx_clk,
  input  logic              reset,
  input  logic              send_trig,
  input  logic [3:0]        led_data_1,
  input  logic [15:0]       dled,
  input  logic [3:0]        key,
  udp_status_tx_if.master   app,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx_drop,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int          ACW         = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [ACW-1:0] ACK_LAST = ACW'(ACK_TIMEOUT - 1);
  localparam logic [31:0] PERIOD_LAST = (PERIOD_CYCLES == 0) ? 32'd0 : 32'(PERIOD_CYCLES - 1);

  state_t          state_q, state_d;
  logic            pending_q, pending_d;
  logic [31:0]     timer_q, timer_d;
  logic [7:0]      seq_q, seq_d;
  logic [3:0]      key_q, key_d;
  logic [3:0]      led_q, led_d;
  logic [15:0]     dled_q, dled_d;
  logic [7:0]      csum_q, csum_d;
  logic [2:0]      idx_q, idx_d;
  logic [ACW-1:0]  ack_cnt_q, ack_cnt_d;
  logic            drop_q, drop_d;

  logic            timer_wrap;
  logic [7:0]      live_csum;
  logic [7:0]      frame_byte;

  // Free-running period timer; it never pauses, so frame starts stay on the period grid.
  always_comb begin
    timer_wrap = (PERIOD_CYCLES != 0) && (timer_q == PERIOD_LAST);
    timer_d    = (PERIOD_CYCLES == 0 || timer_wrap) ? 32'd0 : timer_q + 32'd1;
  end

  always_comb begin
    live_csum = 8'hA5 ^ seq_q ^ {4'h0, key} ^ {4'h0, led_data_1}
              ^ dled[15:8] ^ dled[7:0] ^ 8'h5A;
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | send_trig | timer_wrap;
    seq_d     = seq_q;
    key_d     = key_q;
    led_d     = led_q;
    dled_d    = dled_q;
    csum_d    = csum_q;
    idx_d     = idx_q;
    ack_cnt_d = ack_cnt_q;
    drop_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending_q) begin
          // Events arriving in the same cycle as the launch belong to the next frame.
          pending_d = send_trig | timer_wrap;
          key_d     = key;
          led_d     = led_data_1;
          dled_d    = dled;
          csum_d    = live_csum;
          ack_cnt_d = '0;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (app.app_tx_ack) begin
          idx_d   = 3'd0;
          state_d = SEND;
        end else if (ack_cnt_q == ACK_LAST) begin
          drop_d  = 1'b1;
          state_d = IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end
      SEND: begin
        if (idx_q == 3'd7) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      DONE: begin
        seq_d   = seq_q + 8'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge udp_tx_clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      timer_q   <= 32'd0;
      seq_q     <= 8'd0;
      key_q     <= 4'd0;
      led_q     <= 4'd0;
      dled_q    <= 16'd0;
      csum_q    <= 8'd0;
      idx_q     <= 3'd0;
      ack_cnt_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
      seq_q     <= seq_d;
      key_q     <= key_d;
      led_q     <= led_d;
      dled_q    <= dled_d;
      csum_q    <= csum_d;
      idx_q     <= idx_d;
      ack_cnt_q <= ack_cnt_d;
      drop_q    <= drop_d;
    end
  end

  // Byte 1 reads seq_q live: it only changes in DONE, after the last byte has gone out.
  always_comb begin
    case (idx_q)
      3'd0:    frame_byte = 8'hA5;
      3'd1:    frame_byte = seq_q;
      3'd2:    frame_byte = {4'h0, key_q};
      3'd3:    frame_byte = {4'h0, led_q};
      3'd4:    frame_byte = dled_q[15:8];
      3'd5:    frame_byte = dled_q[7:0];
      3'd6:    frame_byte = 8'h5A;
      default: frame_byte = csum_q;
    endcase
  end

  // Outputs decode straight from state flops so an async reset clears them at once.
  assign app.app_tx_data_request = (state_q == REQ);
  assign app.app_tx_data_valid   = (state_q == SEND);
  assign app.app_tx_data         = (state_q == SEND) ? frame_byte : 8'd0;
  assign app.app_tx_data_length  = (state_q == REQ || state_q == SEND) ? 16'd8 : 16'd0;
  assign tx_busy                 = (state_q != IDLE);
  assign tx_done                 = (state_q == DONE);
  assign tx_drop                 = drop_q;
  assign dbg_state_o             = state_q;

endmodule

// File: tb/tb_udp_status_tx.sv
// Directed bench for udp_status_tx: frame content, handshake timing, timeout, seq wrap,
// snapshot stability, mid-frame reset, and periodic sends with trigger collapsing.
module tb_udp_status_tx;
  logic        clk;
  logic        rst_n;
  logic        send_trig0, send_trig1;
  logic [3:0]  led0, led1, key0, key1;
  logic [15:0] dled0, dled1;
  logic        busy0, done0, drop0, busy1, done1, drop1;
  logic [1:0]  st0, st1;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  exp_q[2][$];
  int          run[2];
  logic [7:0]  seq0;

  udp_status_tx_if if0 ();
  udp_status_tx_if if1 ();

  udp_status_tx #(.PERIOD_CYCLES(0), .ACK_TIMEOUT(16)) dut0 (
    .udp_tx_clk(clk), .reset(rst_n), .send_trig(send_trig0), .led_data_1(led0),
    .dled(dled0), .key(key0), .app(if0), .tx_busy(busy0), .tx_done(done0),
    .tx_drop(drop0), .dbg_state_o(st0)
  );

  udp_status_tx #(.PERIOD_CYCLES(100), .ACK_TIMEOUT(16)) dut1 (
    .udp_tx_clk(clk), .reset(rst_n), .send_trig(send_trig1), .led_data_1(led1),
    .dled(dled1), .key(key1), .app(if1), .tx_busy(busy1), .tx_done(done1),
    .tx_drop(drop1), .dbg_state_o(st1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_frame(input logic [3:0] k, input logic [3:0] l,
                                              input logic [15:0] d, input logic [7:0] s);
    logic [7:0] b[8];
    b[0] = 8'hA5; b[1] = s; b[2] = {4'h0, k}; b[3] = {4'h0, l};
    b[4] = d[15:8]; b[5] = d[7:0]; b[6] = 8'h5A;
    b[7] = 8'h00;
    for (int i = 0; i < 7; i++) b[7] = b[7] ^ b[i];
    return {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
  endfunction

  // scoreboard: every valid byte is popped against the expected queue
  task automatic mon(input int k, input logic v, input logic [7:0] d);
    if (!rst_n) begin
      run[k] = 0;
    end else if (v) begin
      if (exp_q[k].size() == 0) check($sformatf("d%0d_unexpected_valid", k), v, 1'b0);
      else check($sformatf("d%0d_byte", k), d, exp_q[k].pop_front());
      run[k]++;
    end else begin
      check($sformatf("d%0d_idle_data", k), d, 8'h00);
      if (run[k] != 0) begin
        check($sformatf("d%0d_run_len", k), run[k], 8);
        run[k] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, if0.app_tx_data_valid, if0.app_tx_data);
    mon(1, if1.app_tx_data_valid, if1.app_tx_data);
  end

  // driver: one triggered frame on dut0 with full handshake timing checks
  task automatic run_frame0(input logic [3:0] k, input logic [3:0] l, input logic [15:0] d,
                            input int ack_dly, input bit scramble);
    logic [63:0] f;
    key0 = k; led0 = l; dled0 = d;
    f = model_frame(k, l, d, seq0);
    for (int i = 0; i < 8; i++) exp_q[0].push_back(f[63-8*i -: 8]);
    send_trig0 = 1'b1;
    @(negedge clk);
    send_trig0 = 1'b0;
    check("req_not_yet", if0.app_tx_data_request, 1'b0);
    @(negedge clk);
    check("req_high", if0.app_tx_data_request, 1'b1);
    check("req_len", if0.app_tx_data_length, 16'd8);
    check("req_busy", busy0, 1'b1);
    repeat (ack_dly) @(negedge clk);
    check("req_held", if0.app_tx_data_request, 1'b1);
    if0.app_tx_ack = 1'b1;
    @(negedge clk);
    if0.app_tx_ack = 1'b0;
    check("req_dropped", if0.app_tx_data_request, 1'b0);
    check("byte0_valid", if0.app_tx_data_valid, 1'b1);
    if (scramble) begin
      dled0 = 16'hFFFF; key0 = ~k; led0 = ~l;
    end
    repeat (7) @(negedge clk);
    check("byte7_valid", if0.app_tx_data_valid, 1'b1);
    check("send_len", if0.app_tx_data_length, 16'd8);
    @(negedge clk);
    check("done_pulse", done0, 1'b1);
    check("done_len", if0.app_tx_data_length, 16'd0);
    @(negedge clk);
    check("done_low", done0, 1'b0);
    check("busy_low", busy0, 1'b0);
    seq0 = seq0 + 8'd1;
  endtask

  int n, nr, ndone, ntrig;
  int rise[8];
  logic req_prev;
  logic [63:0] fr;

  initial begin
    rst_n = 1'b0;
    send_trig0 = 1'b0; send_trig1 = 1'b0;
    key0 = 4'h0; led0 = 4'h0; dled0 = 16'h0;
    key1 = 4'hA; led1 = 4'h5; dled1 = 16'hBEEF;
    if0.app_tx_ack = 1'b0; if1.app_tx_ack = 1'b0;
    seq0 = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_req", if0.app_tx_data_request, 1'b0);
    check("rst_valid", if0.app_tx_data_valid, 1'b0);
    check("rst_data", if0.app_tx_data, 8'h00);
    check("rst_len", if0.app_tx_data_length, 16'd0);
    check("rst_busy", busy0, 1'b0);
    check("rst_done", done0, 1'b0);
    check("rst_drop", drop0, 1'b0);
    check("rst_state", st0, 2'd0);
    rst_n = 1'b1;

    // ack outside REQ must not start anything
    if0.app_tx_ack = 1'b1;
    repeat (3) @(negedge clk);
    if0.app_tx_ack = 1'b0;
    check("stray_ack_busy", busy0, 1'b0);

    run_frame0(4'h3, 4'h9, 16'h1234, 3, 1'b0);
    run_frame0(4'h3, 4'h9, 16'h1234, 1, 1'b1);
    run_frame0(4'h1, 4'h2, 16'hA55A, 0, 1'b0);
    run_frame0(4'hF, 4'hE, 16'h0F0F, 0, 1'b0);
    while (seq0 != 8'hFF)
      run_frame0(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 16'($urandom_range(0, 65535)), $urandom_range(0, 3), 1'b0);
    run_frame0(4'h7, 4'h8, 16'hCAFE, 2, 1'b0);
    check("seq_wrapped_model", seq0, 8'h00);
    run_frame0(4'h6, 4'h1, 16'h0001, 0, 1'b0);

    // ack timeout: 16 request cycles, drop pulse, seq unchanged
    send_trig0 = 1'b1;
    @(negedge clk);
    send_trig0 = 1'b0;
    @(negedge clk);
    check("to_req_high", if0.app_tx_data_request, 1'b1);
    n = 0;
    while (if0.app_tx_data_request && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("to_req_cycles", n, 16);
    check("to_drop_pulse", drop0, 1'b1);
    @(negedge clk);
    check("to_drop_low", drop0, 1'b0);
    check("to_busy_low", busy0, 1'b0);
    run_frame0(4'h2, 4'h4, 16'h5678, 1, 1'b0);

    // reset during byte 4
    key0 = 4'h3; led0 = 4'h9; dled0 = 16'h1234;
    fr = model_frame(4'h3, 4'h9, 16'h1234, seq0);
    for (int i = 0; i < 5; i++) exp_q[0].push_back(fr[63-8*i -: 8]);
    send_trig0 = 1'b1;
    @(negedge clk);
    send_trig0 = 1'b0;
    @(negedge clk);
    if0.app_tx_ack = 1'b1;
    @(negedge clk);
    if0.app_tx_ack = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", if0.app_tx_data_valid, 1'b0);
    check("mid_rst_req", if0.app_tx_data_request, 1'b0);
    check("mid_rst_busy", busy0, 1'b0);
    check("mid_rst_data", if0.app_tx_data, 8'h00);
    check("mid_rst_len", if0.app_tx_data_length, 16'd0);
    seq0 = 8'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_idle", busy0, 1'b0);
    run_frame0(4'h3, 4'h9, 16'h1234, 0, 1'b0);
    check("d0_queue_drained", exp_q[0].size(), 0);

    // periodic sends on dut1, five trigger pulses during one SEND collapse into one frame
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 5; s++) begin
      fr = model_frame(key1, led1, dled1, 8'(s));
      for (int i = 0; i < 8; i++) exp_q[1].push_back(fr[63-8*i -: 8]);
    end
    rst_n = 1'b1;
    nr = 0; ndone = 0; ntrig = 0; req_prev = 1'b0;
    for (int i = 0; i < 8; i++) rise[i] = 0;
    for (int c = 0; c < 460; c++) begin
      if (if1.app_tx_data_request && !req_prev && nr < 8) begin
        rise[nr] = c;
        nr++;
      end
      req_prev = if1.app_tx_data_request;
      if (done1) ndone++;
      if1.app_tx_ack = if1.app_tx_data_request;
      send_trig1 = if1.app_tx_data_valid && nr == 2 && ntrig < 5;
      if (send_trig1) ntrig++;
      @(negedge clk);
    end
    if1.app_tx_ack = 1'b0;
    send_trig1 = 1'b0;
    check("per_requests", nr, 5);
    check("per_done_count", ndone, 5);
    check("per_trig_pulses", ntrig, 5);
    check("per_gap_0_1", rise[1] - rise[0], 100);
    check("per_gap_1_3", rise[3] - rise[1], 100);
    check("per_gap_3_4", rise[4] - rise[3], 100);
    check("per_extra_early", (rise[2] > rise[1]) && (rise[2] - rise[1] < 100), 1'b1);
    check("d1_queue_drained", exp_q[1].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
